// File: rtl/nibble_sort_seq.sv
// Sequential bubble sorter: one shared compare-and-swap per clock, early exit on a clean pass.
// Element k of d/q occupies bits [k*W +: W]; the result is ascending with the smallest at k=0.
module nibble_sort_seq #(
    parameter int N  = 4,
    parameter int W  = 4,
    parameter int CW = $clog2(N * (N - 1) / 2 + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N*W-1:0] d,
    output logic           busy,
    output logic           done,
    output logic [N*W-1:0] q,
    output logic [CW-1:0]  swaps
);

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST_PASS = IW'(N - 2);

    typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

    state_t        state;
    logic [W-1:0]  arr [N];
    logic [IW-1:0] pass;
    logic [IW-1:0] idx;
    logic          swapped;

    logic [IW-1:0] idx_nx;
    logic [IW-1:0] last_idx;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          gt;

    always_comb begin
        idx_nx   = idx + IW'(1);
        last_idx = LAST_PASS - pass;
        a        = arr[idx];
        b        = arr[idx_nx];
        // Strict compare keeps equal elements in place.
        gt       = a > b;
    end

    always_comb begin
        q = '0;
        for (int k = 0; k < N; k++) begin
            q[k*W +: W] = arr[k];
        end
    end

    assign busy = (state == SORT);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            swaps   <= '0;
            pass    <= '0;
            idx     <= '0;
            swapped <= 1'b0;
            for (int k = 0; k < N; k++) begin
                arr[k] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        for (int k = 0; k < N; k++) begin
                            arr[k] <= d[k*W +: W];
                        end
                        swaps   <= '0;
                        pass    <= '0;
                        idx     <= '0;
                        swapped <= 1'b0;
                        state   <= SORT;
                    end
                end
                SORT: begin
                    if (gt) begin
                        arr[idx]    <= b;
                        arr[idx_nx] <= a;
                        swaps       <= swaps + CW'(1);
                    end
                    if (idx == last_idx) begin
                        // A clean pass (counting this compare) means the array is sorted.
                        if (!(swapped || gt) || pass == LAST_PASS) begin
                            state <= DONE;
                        end else begin
                            pass    <= pass + IW'(1);
                            idx     <= '0;
                            swapped <= 1'b0;
                        end
                    end else begin
                        idx     <= idx_nx;
                        swapped <= swapped | gt;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_sort_seq.sv
// Bench for nibble_sort_seq: directed handshake/reset cases plus random sorts
// checked against an array-based bubble-sort reference.
module tb_nibble_sort_seq;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int CW = $clog2(N * (N - 1) / 2 + 1);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [N*W-1:0] d = '0;
    logic           busy;
    logic           done;
    logic [N*W-1:0] q;
    logic [CW-1:0]  swaps;

    int total = 0;
    int bad = 0;
    int done_count = 0;

    nibble_sort_seq #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .d     (d),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .swaps (swaps)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_count++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference: textbook bubble sort with early exit over a plain int array.
    task automatic ref_sort(input logic [N*W-1:0] din, output logic [N*W-1:0] qout,
                            output int nswap, output int ncmp);
        int  arr[N];
        int  t;
        bit  any;
        for (int k = 0; k < N; k++) arr[k] = int'(din[k*W +: W]);
        nswap = 0;
        ncmp  = 0;
        for (int p = 0; p < N - 1; p++) begin
            any = 0;
            for (int i = 0; i < N - 1 - p; i++) begin
                ncmp++;
                if (arr[i] > arr[i+1]) begin
                    t = arr[i]; arr[i] = arr[i+1]; arr[i+1] = t;
                    nswap++;
                    any = 1;
                end
            end
            if (!any) break;
        end
        qout = '0;
        for (int k = 0; k < N; k++) qout[k*W +: W] = W'(arr[k]);
    endtask

    // Starts at #1 after an edge with the DUT idle; ends #1 after the edge leaving DONE.
    task automatic run_sort(input logic [N*W-1:0] din, input string tag,
                            output logic [N*W-1:0] qres, output int sres);
        logic [N*W-1:0] eq;
        int es, ec, nb, dc0;
        ref_sort(din, eq, es, ec);
        dc0   = done_count;
        d     = din;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        d     = ~din;
        nb    = 0;
        while (busy && nb < 100) begin
            nb++;
            @(posedge clk); #1;
        end
        chk({tag, ".busy_cycles"}, nb, ec);
        chk({tag, ".done"}, {31'd0, done}, 32'd1);
        chk({tag, ".q"}, {16'd0, q}, {16'd0, eq});
        chk({tag, ".swaps"}, {29'd0, swaps}, es);
        qres = q;
        sres = int'(swaps);
        @(posedge clk); #1;
        chk({tag, ".idle"}, {30'd0, done, busy}, 32'd0);
        chk({tag, ".done_pulses"}, done_count - dc0, 32'd1);
    endtask

    initial begin
        logic [N*W-1:0] qr;
        logic [N*W-1:0] rd;
        int sr, nb;

        #12;
        chk("reset.busy", {31'd0, busy}, 32'd0);
        chk("reset.done", {31'd0, done}, 32'd0);
        chk("reset.q", {16'd0, q}, 32'd0);
        chk("reset.swaps", {29'd0, swaps}, 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        run_sort(16'h1234, "reverse", qr, sr);
        chk("reverse.q_const", {16'd0, qr}, 32'h4321);
        chk("reverse.swaps_const", sr, 32'd6);

        run_sort(16'h4321, "sorted", qr, sr);
        chk("sorted.swaps_const", sr, 32'd0);

        run_sort(16'h2121, "dups", qr, sr);
        chk("dups.q_const", {16'd0, qr}, 32'h2211);
        chk("dups.swaps_const", sr, 32'd1);

        // start held high through SORT and DONE; d changes after acceptance.
        d = 16'h1234;
        start = 1'b1;
        @(posedge clk); #1;
        d = 16'hFFFF;
        nb = 0;
        while (busy && nb < 100) begin
            nb++;
            @(posedge clk); #1;
        end
        chk("held.busy_cycles", nb, 32'd6);
        chk("held.done", {31'd0, done}, 32'd1);
        chk("held.q", {16'd0, q}, 32'h4321);
        @(posedge clk); #1;
        chk("held.idle_after_done", {30'd0, done, busy}, 32'd0);
        @(posedge clk); #1;
        chk("held.reaccept", {31'd0, busy}, 32'd1);
        chk("held.reaccept_q", {16'd0, q}, 32'hFFFF);
        start = 1'b0;
        nb = 0;
        while (!done && nb < 100) begin
            nb++;
            @(posedge clk); #1;
        end
        chk("held.second_done", {31'd0, done}, 32'd1);
        @(posedge clk); #1;

        // Async reset in the third SORT cycle, between edges.
        d = 16'h1234;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        chk("abort.busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort.busy", {31'd0, busy}, 32'd0);
        chk("abort.done", {31'd0, done}, 32'd0);
        chk("abort.q", {16'd0, q}, 32'd0);
        chk("abort.swaps", {29'd0, swaps}, 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("abort.idle", {30'd0, done, busy}, 32'd0);
        run_sort(16'h0F1E, "after_reset", qr, sr);
        chk("after_reset.q_const", {16'd0, qr}, 32'hFE10);

        // Back-to-back: second start is raised in the IDLE cycle right after done.
        run_sort(16'h1234, "b2b_first", qr, sr);
        run_sort(16'h8A3C, "b2b_second", qr, sr);
        chk("b2b_second.q_const", {16'd0, qr}, 32'hCA83);

        for (int i = 0; i < 25; i++) begin
            rd = 16'($urandom);
            run_sort(rd, $sformatf("rand%0d", i), qr, sr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
